// File: rtl/tespar_pkg.sv
// Shared constants and the (D,S) to alphabet-symbol mapping used by the
// TESPAR epoch generator and window extractor.
package tespar_pkg;

   localparam int ALPHA_COUNT = 8;
   localparam int SYM_W       = 4;
   localparam int D_SHORT_MAX = 5;
   localparam int D_MID_MAX   = 7;
   localparam int D_LONG_MAX  = 10;
   localparam int S_MAX       = 2;

   // Symbol 0 marks an epoch outside the alphabet.
   function automatic logic [SYM_W-1:0] map_symbol(input int d, input int s);
      logic [SYM_W-1:0] r;
      if ((d == 32'sd0) || (d > D_LONG_MAX) || (s > S_MAX)) begin
         r = 4'd0;
      end else if (d <= D_SHORT_MAX) begin
         r = SYM_W'(d);
      end else if (d <= D_MID_MAX) begin
         r = 4'd6;
      end else if (s == 32'sd0) begin
         r = 4'd7;
      end else begin
         r = 4'd8;
      end
      return r;
   endfunction

endpackage

// File: rtl/tespar_epoch_gen.sv
// Segments the accepted sample stream at zero crossings, measures each epoch's
// duration and minima count, and registers the resulting symbol.
module tespar_epoch_gen
   import tespar_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int D_W    = 5,
   parameter int S_W    = 3
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     sym_valid,
   output logic [SYM_W-1:0]         sym,
   output logic [D_W-1:0]           sym_d,
   output logic [S_W-1:0]           sym_s
);

   logic signed [DATA_W-1:0] prev_r;
   logic signed [DATA_W-1:0] prev2_r;
   logic                     primed_r;
   logic                     first_r;
   logic [D_W-1:0]           d_r;
   logic [S_W-1:0]           s_r;
   logic                     sym_valid_r;
   logic [SYM_W-1:0]         sym_r;
   logic [D_W-1:0]           sym_d_r;
   logic [S_W-1:0]           sym_s_r;
   logic                     crossing_s;
   logic                     minimum_s;

   // Crossing and local-minimum detection; prev2 only belongs to this epoch once D >= 2.
   always_comb begin
      crossing_s = primed_r && (data_in[DATA_W-1] != prev_r[DATA_W-1]);
      minimum_s  = (d_r >= D_W'(2)) && (prev_r < prev2_r) && (prev_r < data_in);
   end

   // Epoch counters and symbol register; the first epoch after a flush has an unknown start.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         prev_r      <= '0;
         prev2_r     <= '0;
         primed_r    <= 1'b0;
         first_r     <= 1'b0;
         d_r         <= '0;
         s_r         <= '0;
         sym_valid_r <= 1'b0;
         sym_r       <= '0;
         sym_d_r     <= '0;
         sym_s_r     <= '0;
      end else begin
         sym_valid_r <= 1'b0;
         if (in_valid) begin
            prev_r  <= data_in;
            prev2_r <= prev_r;
            if (!primed_r) begin
               primed_r <= 1'b1;
               first_r  <= 1'b1;
               d_r      <= D_W'(1);
               s_r      <= '0;
            end else if (crossing_s) begin
               first_r <= 1'b0;
               d_r     <= D_W'(1);
               s_r     <= '0;
               if (!first_r) begin
                  sym_valid_r <= 1'b1;
                  sym_r       <= map_symbol(32'(d_r), 32'(s_r));
                  sym_d_r     <= d_r;
                  sym_s_r     <= s_r;
               end
            end else begin
               if (d_r != {D_W{1'b1}}) begin
                  d_r <= d_r + D_W'(1);
               end
               if (minimum_s && (s_r != {S_W{1'b1}})) begin
                  s_r <= s_r + S_W'(1);
               end
            end
         end
      end
   end

   assign sym_valid = sym_valid_r;
   assign sym       = sym_r;
   assign sym_d     = sym_d_r;
   assign sym_s     = sym_s_r;

endmodule

// File: rtl/tespar_window_extractor.sv
// TESPAR front end: epoch symbols feed a sliding-window histogram whose bins
// are snapshotted into feature_vector every HOP symbols once the window is full.
module tespar_window_extractor
   import tespar_pkg::*;
#(
   parameter  int DATA_W      = 8,
   parameter  int D_W         = 5,
   parameter  int S_W         = 3,
   parameter  int WINDOW_SIZE = 256,
   parameter  int HOP         = 64,
   localparam int CNT_W       = $clog2(WINDOW_SIZE + 1)
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   output logic                     sym_valid,
   output logic [3:0]               sym,
   output logic [D_W-1:0]           sym_d,
   output logic [S_W-1:0]           sym_s,
   output logic                     window_full,
   output logic                     feat_valid,
   output logic [8*CNT_W-1:0]       feature_vector
);

   localparam int PTR_W = $clog2(WINDOW_SIZE);
   localparam int HOP_W = $clog2(HOP + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WINDOW_SIZE);

   logic [SYM_W-1:0]         ram_r [WINDOW_SIZE];
   logic [PTR_W-1:0]         wr_ptr_r;
   logic [CNT_W-1:0]         fill_r;
   logic [HOP_W-1:0]         hop_r;
   logic                     window_full_r;
   logic                     snap_pend_r;
   logic                     feat_valid_r;
   logic [8*CNT_W-1:0]       feature_vector_r;
   logic [CNT_W-1:0]         bins_r      [ALPHA_COUNT];
   logic [CNT_W-1:0]         bins_next_s [ALPHA_COUNT];
   logic [SYM_W-1:0]         old_sym_s;
   logic                     full_s;
   logic                     snap_s;
   logic [HOP_W-1:0]         hop_next_s;
   logic [8*CNT_W-1:0]       bins_packed_s;

   tespar_epoch_gen #(
      .DATA_W (DATA_W),
      .D_W    (D_W),
      .S_W    (S_W)
   ) u_epoch_gen (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .sym_valid (sym_valid),
      .sym       (sym),
      .sym_d     (sym_d),
      .sym_s     (sym_s)
   );

   // Next histogram state and snapshot decision; the evicted symbol is read before it is overwritten.
   always_comb begin
      old_sym_s     = ram_r[wr_ptr_r];
      full_s        = (fill_r == FULL_CNT);
      hop_next_s    = hop_r + HOP_W'(1);
      snap_s        = 1'b0;
      bins_packed_s = '0;
      if (sym_valid) begin
         if (full_s) begin
            snap_s = (hop_next_s == HOP_W'(HOP));
         end else begin
            snap_s = (fill_r == (FULL_CNT - CNT_W'(1)));
         end
      end else begin
         snap_s = 1'b0;
      end
      for (int k = 0; k < ALPHA_COUNT; k++) begin
         bins_next_s[k] = bins_r[k];
         if (sym_valid && (sym == SYM_W'(k + 1)) && !(full_s && (old_sym_s == SYM_W'(k + 1)))) begin
            bins_next_s[k] = bins_r[k] + CNT_W'(1);
         end else if (sym_valid && full_s && (old_sym_s == SYM_W'(k + 1)) && (sym != SYM_W'(k + 1))) begin
            bins_next_s[k] = bins_r[k] - CNT_W'(1);
         end else begin
            bins_next_s[k] = bins_r[k];
         end
         bins_packed_s[k*CNT_W +: CNT_W] = bins_r[k];
      end
   end

   // Symbol storage; contents are never cleared because fill_r gates every eviction.
   always_ff @(posedge clk) begin
      if (sym_valid && !(reset || clear)) begin
         ram_r[wr_ptr_r] <= sym;
      end
   end

   // Window bookkeeping, histogram bins and the one-cycle-delayed feature snapshot.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_r         <= '0;
         fill_r           <= '0;
         hop_r            <= '0;
         window_full_r    <= 1'b0;
         snap_pend_r      <= 1'b0;
         feat_valid_r     <= 1'b0;
         feature_vector_r <= '0;
         for (int k = 0; k < ALPHA_COUNT; k++) begin
            bins_r[k] <= '0;
         end
      end else begin
         snap_pend_r  <= snap_s;
         feat_valid_r <= snap_pend_r;
         if (snap_pend_r) begin
            feature_vector_r <= bins_packed_s;
         end
         if (sym_valid) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            for (int k = 0; k < ALPHA_COUNT; k++) begin
               bins_r[k] <= bins_next_s[k];
            end
            if (full_s) begin
               hop_r <= snap_s ? '0 : hop_next_s;
            end else begin
               fill_r        <= fill_r + CNT_W'(1);
               hop_r         <= '0;
               window_full_r <= (fill_r == (FULL_CNT - CNT_W'(1)));
            end
         end
      end
   end

   assign window_full    = window_full_r;
   assign feat_valid     = feat_valid_r;
   assign feature_vector = feature_vector_r;

endmodule

// File: tb/tb_tespar_window_extractor.sv
// Scoreboard bench for tespar_window_extractor (WINDOW_SIZE=8, HOP=4) driven
// by directed sample sequences with hand-computed symbols and snapshots.
module tb_tespar_window_extractor;

   localparam int DATA_W = 8;
   localparam int D_W    = 5;
   localparam int S_W    = 3;
   localparam int WS     = 8;
   localparam int HOP    = 4;
   localparam int CNT_W  = $clog2(WS + 1);

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     clear = 1'b0;
   logic                     in_valid = 1'b0;
   logic signed [DATA_W-1:0] data_in = '0;
   logic                     sym_valid;
   logic [3:0]               sym;
   logic [D_W-1:0]           sym_d;
   logic [S_W-1:0]           sym_s;
   logic                     window_full;
   logic                     feat_valid;
   logic [8*CNT_W-1:0]       feature_vector;

   typedef struct packed {
      logic [3:0]     sym;
      logic [D_W-1:0] d;
      logic [S_W-1:0] s;
   } sym_t;

   sym_t               sym_q  [$];
   logic [8*CNT_W-1:0] feat_q [$];
   int n_total = 0;
   int n_pass  = 0;

   tespar_window_extractor #(
      .DATA_W      (DATA_W),
      .D_W         (D_W),
      .S_W         (S_W),
      .WINDOW_SIZE (WS),
      .HOP         (HOP)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .clear          (clear),
      .in_valid       (in_valid),
      .data_in        (data_in),
      .sym_valid      (sym_valid),
      .sym            (sym),
      .sym_d          (sym_d),
      .sym_s          (sym_s),
      .window_full    (window_full),
      .feat_valid     (feat_valid),
      .feature_vector (feature_vector)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [8*CNT_W-1:0] mk_fv(input int b1, b2, b3, b4, b5, b6, b7, b8);
      return {CNT_W'(b8), CNT_W'(b7), CNT_W'(b6), CNT_W'(b5),
              CNT_W'(b4), CNT_W'(b3), CNT_W'(b2), CNT_W'(b1)};
   endfunction

   task automatic exp_sym(input int s_sym, input int d, input int s);
      sym_t e;
      e.sym = 4'(s_sym);
      e.d   = D_W'(d);
      e.s   = S_W'(s);
      sym_q.push_back(e);
   endtask

   task automatic send(input int v);
      @(negedge clk);
      in_valid = 1'b1;
      data_in  = DATA_W'(v);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain(input string nm);
      int t = 0;
      while (((sym_q.size() != 0) || (feat_q.size() != 0)) && (t < 300)) begin
         @(negedge clk);
         t++;
      end
      check(nm, 64'(sym_q.size() + feat_q.size()), 64'd0);
      idle(4);
   endtask

   // Monitor: every DUT output event is matched against the scoreboard queues.
   always @(negedge clk) begin
      if (!reset) begin
         if (sym_valid) begin
            if (sym_q.size() == 0) begin
               check("sym_unexpected", 64'({sym, sym_d, sym_s}), 64'd0);
            end else begin
               sym_t e;
               e = sym_q.pop_front();
               check("sym", 64'({sym, sym_d, sym_s}), 64'({e.sym, e.d, e.s}));
            end
         end
         if (feat_valid) begin
            if (feat_q.size() == 0) begin
               check("feat_unexpected", 64'(feature_vector), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               check("feat", 64'(feature_vector), 64'(feat_q.pop_front()));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_outputs", 64'({sym_valid, sym, sym_d, sym_s, window_full, feat_valid}), 64'd0);
      check("reset_fv", 64'(feature_vector), 64'd0);

      // Square wave period 4: first epoch dropped, then D=2 symbols fill the window.
      for (int k = 0; k < 8; k++) exp_sym(2, 2, 0);
      feat_q.push_back(mk_fv(0, 8, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++) send(((i / 2) % 2) != 0 ? -50 : 50);
      idle(1);
      drain("drain_fill");
      check("window_full_after_fill", 64'(window_full), 64'd1);

      // Same square wave with in_valid gaps: identical symbols.
      for (int k = 0; k < 3; k++) exp_sym(2, 2, 0);
      for (int i = 20; i < 26; i++) begin
         send(((i / 2) % 2) != 0 ? -50 : 50);
         idle(1);
      end

      // Period-2 wave: last D=2 epoch, then eight D=1 symbols replace the twos.
      exp_sym(2, 2, 0);
      feat_q.push_back(mk_fv(0, 8, 0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 8; k++) begin
         exp_sym(1, 1, 0);
         if (k == 4) feat_q.push_back(mk_fv(4, 4, 0, 0, 0, 0, 0, 0));
         if (k == 8) feat_q.push_back(mk_fv(8, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 26; i < 35; i++) send((i % 2) != 0 ? 50 : -50);
      idle(1);
      drain("drain_period2");

      // Length-9 epochs: two minima gives sym 8, monotonic gives sym 7.
      exp_sym(1, 1, 0);
      exp_sym(8, 9, 2);
      exp_sym(7, 9, 0);
      send(1); send(9); send(3); send(9); send(2);
      send(9); send(9); send(9); send(9);
      for (int i = 1; i <= 9; i++) send(-i);

      // 40-sample epoch saturates D at 31 and maps to symbol 0.
      exp_sym(0, 31, 0);
      feat_q.push_back(mk_fv(5, 0, 0, 0, 0, 0, 1, 1));
      for (int i = 0; i < 40; i++) send(5);
      send(-7);
      idle(1);
      drain("drain_long");
      check("window_full_before_clear", 64'(window_full), 64'd1);

      // Clear mid-stream flushes everything; the next window must rebuild from empty bins.
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear_window_full", 64'(window_full), 64'd0);
      check("clear_fv", 64'(feature_vector), 64'd0);
      check("clear_valids", 64'({sym_valid, feat_valid}), 64'd0);
      for (int k = 0; k < 8; k++) exp_sym(2, 2, 0);
      feat_q.push_back(mk_fv(0, 8, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 20; i++) send(((i / 2) % 2) != 0 ? -50 : 50);
      idle(1);
      drain("drain_after_clear");
      check("window_full_after_refill", 64'(window_full), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
